// File: rtl/adc_mac_pkg.sv
// Shared types and width helpers for the multi-channel sample-buffer / MAC engine.
package adc_mac_pkg;

    typedef enum logic [1:0] {
        CAPTURE,
        CALC,
        SUM
    } state_t;

    // Width of a tap pointer for a buffer of the given depth.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Width of a channel index; a single channel still gets one bit.
    function automatic int ch_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/adc_mac_channel.sv
// One channel: sample buffer, coefficient store and a signed multiply-accumulate
// stepped one tap per cycle by the top-level sequencer.
module adc_mac_channel
    import adc_mac_pkg::*;
#(
    parameter int DATA_W = 12,
    parameter int COEF_W = 8,
    parameter int DEPTH  = 10,
    parameter int ACC_W  = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sample_we,
    input  logic [ptr_w(DEPTH)-1:0]    wr_ptr,
    input  logic [DATA_W-1:0]          sample,
    input  logic                       coef_we,
    input  logic [ptr_w(DEPTH)-1:0]    coef_addr,
    input  logic [COEF_W-1:0]          coef_data,
    input  logic                       acc_clr,
    input  logic                       acc_en,
    input  logic [ptr_w(DEPTH)-1:0]    rd_ptr,
    output logic [ACC_W-1:0]           acc
);

    localparam int PW     = ptr_w(DEPTH);
    localparam int PROD_W = DATA_W + COEF_W + 1;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic        [DATA_W-1:0] smp_mem  [DEPTH];
    logic signed [COEF_W-1:0] coef_mem [DEPTH];

    logic signed [DATA_W:0]   tap_smp;
    logic signed [COEF_W-1:0] tap_coef;
    logic signed [PROD_W-1:0] prod;

    // Samples are unsigned, so a zero MSB keeps them positive in the signed product.
    assign tap_smp  = $signed({1'b0, smp_mem[rd_ptr]});
    assign tap_coef = coef_mem[rd_ptr];
    assign prod     = tap_smp * tap_coef;

    // NOTE: the sample buffer is deliberately left out of reset so it maps onto plain
    // RAM; every entry is rewritten before it is read in a frame.
    always_ff @(posedge clk) begin
        if (sample_we) begin
            smp_mem[wr_ptr] <= sample;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                coef_mem[i] <= '0;
            end
        end else if (coef_we && coef_addr <= LAST) begin
            coef_mem[coef_addr] <= coef_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || acc_clr) begin
            acc <= '0;
        end else if (acc_en) begin
            acc <= acc + {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
        end
    end

endmodule

// File: rtl/adc_mac_array.sv
// Frame sequencer: captures DEPTH samples per channel, runs all channel MACs in
// parallel, then adds the channel sums into one result with a valid pulse.
module adc_mac_array
    import adc_mac_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int DATA_W = 12,
    parameter int COEF_W = 8,
    parameter int DEPTH  = 10,
    parameter int ACC_W  = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sample_valid,
    input  logic [NUM_CH*DATA_W-1:0]   sample_data,
    input  logic                       coef_we,
    input  logic [ch_w(NUM_CH)-1:0]    coef_ch,
    input  logic [ptr_w(DEPTH)-1:0]    coef_addr,
    input  logic [COEF_W-1:0]          coef_data,
    output logic [ACC_W-1:0]           output_data,
    output logic                       out_valid,
    output logic                       led,
    output logic                       busy,
    output logic                       overrun
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = ch_w(NUM_CH);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    if (ACC_W < DATA_W + COEF_W + 1 + $clog2(DEPTH * NUM_CH)) begin : g_acc_w_check
        $error("adc_mac_array: ACC_W too narrow for DATA_W, COEF_W, DEPTH and NUM_CH");
    end

    state_t state, state_next;

    logic [PW-1:0]           wr_ptr, rd_ptr;
    logic                    sample_we, acc_clr, acc_en, sum_fire;
    logic [NUM_CH-1:0]       coef_hit;
    logic [NUM_CH*ACC_W-1:0] acc_flat;
    logic [ACC_W-1:0]        frame_sum;

    assign busy = (state != CAPTURE);

    // NOTE: every signal driven here gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        sample_we  = 1'b0;
        acc_clr    = 1'b0;
        acc_en     = 1'b0;
        sum_fire   = 1'b0;
        unique case (state)
            CAPTURE: begin
                if (sample_valid) begin
                    sample_we = 1'b1;
                    if (wr_ptr == LAST) begin
                        acc_clr    = 1'b1;
                        state_next = CALC;
                    end
                end
            end
            CALC: begin
                acc_en = 1'b1;
                if (rd_ptr == LAST) begin
                    state_next = SUM;
                end
            end
            SUM: begin
                sum_fire   = 1'b1;
                state_next = CAPTURE;
            end
            default: state_next = CAPTURE;
        endcase
    end

    // Out-of-range channel indices match no channel, so those writes fall away.
    always_comb begin
        coef_hit = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            coef_hit[c] = coef_we && (state == CAPTURE) && (coef_ch == CW'(c));
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        adc_mac_channel #(
            .DATA_W (DATA_W),
            .COEF_W (COEF_W),
            .DEPTH  (DEPTH),
            .ACC_W  (ACC_W)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .sample_we (sample_we),
            .wr_ptr    (wr_ptr),
            .sample    (sample_data[g*DATA_W +: DATA_W]),
            .coef_we   (coef_hit[g]),
            .coef_addr (coef_addr),
            .coef_data (coef_data),
            .acc_clr   (acc_clr),
            .acc_en    (acc_en),
            .rd_ptr    (rd_ptr),
            .acc       (acc_flat[g*ACC_W +: ACC_W])
        );
    end

    // Two's-complement addition is sign-agnostic, so wrap-around needs no special care.
    always_comb begin
        frame_sum = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            frame_sum = frame_sum + acc_flat[c*ACC_W +: ACC_W];
        end
    end

    // NOTE: non-blocking assignments make every register here sample the values from
    // before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= CAPTURE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            output_data <= '0;
            out_valid   <= 1'b0;
            led         <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            state     <= state_next;
            out_valid <= sum_fire;
            if (sample_valid && busy) begin
                overrun <= 1'b1;
            end
            if (sample_we) begin
                wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (acc_clr) begin
                rd_ptr <= '0;
            end else if (acc_en && rd_ptr != LAST) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (sum_fire) begin
                output_data <= frame_sum;
                led         <= 1'b1;
                wr_ptr      <= '0;
            end
        end
    end

endmodule

// File: tb/tb_adc_mac_array.sv
// Scoreboard bench: the stimulus side predicts each frame result from a
// sample/coefficient model; a separate monitor compares whenever out_valid fires.
module tb_adc_mac_array;

    localparam int NUM_CH = 2;
    localparam int DATA_W = 12;
    localparam int COEF_W = 8;
    localparam int DEPTH  = 10;
    localparam int ACC_W  = 32;
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int ADDR_W = $clog2(DEPTH);

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     sample_valid = 1'b0;
    logic [NUM_CH*DATA_W-1:0] sample_data = '0;
    logic                     coef_we = 1'b0;
    logic [CH_W-1:0]          coef_ch = '0;
    logic [ADDR_W-1:0]        coef_addr = '0;
    logic [COEF_W-1:0]        coef_data = '0;
    logic [ACC_W-1:0]         output_data;
    logic                     out_valid, led, busy, overrun;

    adc_mac_array #(
        .NUM_CH (NUM_CH), .DATA_W (DATA_W), .COEF_W (COEF_W), .DEPTH (DEPTH), .ACC_W (ACC_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .coef_we      (coef_we),
        .coef_ch      (coef_ch),
        .coef_addr    (coef_addr),
        .coef_data    (coef_data),
        .output_data  (output_data),
        .out_valid    (out_valid),
        .led          (led),
        .busy         (busy),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        longint res;
        int     due;
    } exp_t;
    exp_t sb[$];

    // Reference model: coefficient table, samples of the frame being filled, and the
    // window of stamps during which the engine is computing and ignores input.
    longint coef_m [NUM_CH][DEPTH];
    longint smp_m  [NUM_CH][DEPTH];
    int     cnt_m        = 0;
    int     last_m       = -1;
    int     busy_until_m = -1;
    bit     ovr_m        = 1'b0;

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic longint wrap(input longint v);
        logic [ACC_W-1:0] t;
        t = v[ACC_W-1:0];
        return longint'($signed(t));
    endfunction

    function automatic bit busy_at(input int s);
        return (s > last_m) && (s <= busy_until_m);
    endfunction

    function automatic logic [NUM_CH*DATA_W-1:0] pack2(input int a, input int b);
        logic [DATA_W-1:0] la, lb;
        la = a[DATA_W-1:0];
        lb = b[DATA_W-1:0];
        return {lb, la};
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++)
            for (int i = 0; i < DEPTH; i++) coef_m[c][i] = 0;
        cnt_m        = 0;
        last_m       = -1;
        busy_until_m = -1;
        ovr_m        = 1'b0;
        sb.delete();
    endtask

    // Drive one cycle of stimulus at the falling edge and advance the model.
    task automatic step(input bit sv, input logic [NUM_CH*DATA_W-1:0] sd, input bit we,
                        input int ch, input int addr, input int cd);
        logic [CH_W-1:0]   ch_t;
        logic [ADDR_W-1:0] a_t;
        logic [COEF_W-1:0] cd_t;
        int                s;
        bit                b;
        longint            acc;
        @(negedge clk);
        ch_t = ch[CH_W-1:0];
        a_t  = addr[ADDR_W-1:0];
        cd_t = cd[COEF_W-1:0];
        sample_valid = sv;
        sample_data  = sd;
        coef_we      = we;
        coef_ch      = ch_t;
        coef_addr    = a_t;
        coef_data    = cd_t;
        s = cyc;
        b = busy_at(s);
        if (we && !b && int'(ch_t) < NUM_CH && int'(a_t) < DEPTH)
            coef_m[ch_t][a_t] = longint'($signed(cd_t));
        if (sv) begin
            if (b) begin
                ovr_m = 1'b1;
            end else begin
                for (int c = 0; c < NUM_CH; c++) smp_m[c][cnt_m] = sd[c*DATA_W +: DATA_W];
                cnt_m++;
                if (cnt_m == DEPTH) begin
                    acc = 0;
                    for (int c = 0; c < NUM_CH; c++)
                        for (int i = 0; i < DEPTH; i++) acc += smp_m[c][i] * coef_m[c][i];
                    sb.push_back('{res: wrap(acc), due: s + DEPTH + 2});
                    last_m       = s;
                    busy_until_m = s + DEPTH + 1;
                    cnt_m        = 0;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, '0, 1'b0, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        sample_valid = 1'b0;
        coef_we = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 200) begin
            idle(1);
            n++;
        end
        check("drain_pending", sb.size(), 0);
        idle(2);
    endtask

    task automatic load_coefs(input int c0, input int c1);
        for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1, 0, i, c0);
        for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1, 1, i, c1);
    endtask

    // Monitor: settles just after the falling edge, after the driver has acted.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (!rst) begin
                if (out_valid) begin
                    if (sb.size() == 0) begin
                        check("out_valid_unexpected", out_valid, 0);
                    end else begin
                        e = sb.pop_front();
                        check("output_data", $signed(output_data), e.res);
                        check("out_valid_latency", cyc, e.due);
                        check("led_with_result", led, 1);
                    end
                end else if (sb.size() > 0 && cyc > sb[0].due) begin
                    e = sb.pop_front();
                    check("out_valid_missing", out_valid, 1);
                end
                check("busy", busy, busy_at(cyc));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        do_reset();
        idle(20);
        check("rst_output_data", output_data, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_led", led, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);

        // Unit coefficients, ramp on channel 0, constant on channel 1.
        load_coefs(1, 1);
        for (int i = 0; i < DEPTH; i++) step(1'b1, pack2(i + 1, 100), 1'b0, 0, 0, 0);
        drain();
        check("frame_ramp_result", $signed(output_data), 1055);
        check("frame_ramp_led", led, 1);

        // Full-scale samples against -1 taps.
        load_coefs(-1, 0);
        for (int i = 0; i < DEPTH; i++)
            step(1'b1, pack2(4095, $urandom_range(0, 4095)), 1'b0, 0, 0, 0);
        drain();
        check("frame_neg_result", $signed(output_data), -40950);
        check("overrun_clear", overrun, 0);

        // Sample and coefficient write while computing: both dropped.
        for (int i = 0; i < DEPTH; i++)
            step(1'b1, pack2($urandom_range(0, 4095), $urandom_range(0, 4095)), 1'b0, 0, 0, 0);
        idle(3);
        step(1'b1, pack2(7, 7), 1'b1, 0, 0, 77);
        idle(1);
        check("overrun_set", overrun, 1);
        drain();
        for (int i = 0; i < DEPTH; i++)
            step(1'b1, pack2($urandom_range(0, 4095), $urandom_range(0, 4095)), 1'b0, 0, 0, 0);
        drain();
        check("overrun_sticky", overrun, 1);

        // Reset in the fifth compute cycle aborts the frame.
        for (int i = 0; i < DEPTH; i++)
            step(1'b1, pack2($urandom_range(0, 4095), $urandom_range(0, 4095)), 1'b0, 0, 0, 0);
        idle(4);
        do_reset();
        idle(20);
        check("abort_led", led, 0);
        check("abort_overrun", overrun, 0);
        check("abort_output_data", output_data, 0);
        load_coefs(3, -2);
        for (int i = 0; i < DEPTH; i++)
            step(1'b1, pack2($urandom_range(0, 4095), $urandom_range(0, 4095)), 1'b0, 0, 0, 0);
        drain();

        // Random traffic: samples and coefficient writes at any time, including busy.
        for (int c = 0; c < NUM_CH; c++)
            for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1, c, i, $urandom);
        for (int k = 0; k < 600; k++)
            step(1'($urandom_range(0, 1)),
                 pack2($urandom_range(0, 4095), $urandom_range(0, 4095)),
                 ($urandom_range(0, 3) == 0), $urandom_range(0, NUM_CH), $urandom_range(0, DEPTH - 1),
                 $urandom);
        drain();
        check("random_overrun", overrun, ovr_m);
        check("random_led", led, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
